load_store_unit: RTL
====================

# load_store_unit

Data-memory access stage placed directly downstream of the CPU execute logic. It accepts one load or store request per transaction through a valid/ready handshake and drives a word-wide data RAM port that may insert wait states. For stores it generates byte-lane strobes and replicated write data; for loads it aligns the addressed lane and applies sign or zero extension. Misaligned or illegal accesses, and memories that never acknowledge, return an error instead of hanging the CPU.

## Interface
- TIMEOUT, 15, maximum cycles in ACCESS without mem_ack before aborting; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low bits.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned, illegal funct3 or timeout.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  write enable.
- mem_addr  out  30  word address, req_addr[31:2].
- mem_wstrb  out  4  byte-lane write strobes; 0000 on loads.
- mem_wdata  out  32  lane-replicated write data.
- mem_ack  in  1  memory completes the access in this cycle; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, register we, funct3, addr[1:0], mem_addr, strobes and wdata, then check legality:
  - Illegal: loads with funct3 011, 110 or 111; stores with funct3 of 011 or above.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
  - Legal requests go to ACCESS. Illegal or misaligned requests go to RESP with err=1 and never assert mem_req.
- ACCESS: mem_req=1, with mem_we, mem_addr, mem_wstrb and mem_wdata stable.
  - On mem_ack, capture the extended load result and go to RESP with err=0.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT, go to RESP with err=1 and rdata=0.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Store data:
  - B: mem_wdata={4{wdata[7:0]}}, mem_wstrb=0001<<addr[1:0].
  - H: mem_wdata={2{wdata[15:0]}}, mem_wstrb=0011<<addr[1:0].
  - W: mem_wdata=wdata, mem_wstrb=1111.
- Load data: select lane byte addr[1:0] or half addr[1].
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W passes the word through unchanged.
- The wait counter is 8 bits and is cleared on every entry to ACCESS.

## Timing
- Reset (asynchronous): state IDLE. All outputs 0 except req_ready=1. Registered payloads and the wait counter are cleared.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or mem_* inputs to outputs.
- Legal access: accept at edge N. mem_req is high during cycle N+1. If mem_ack arrives in cycle N+k (k≥1), rsp_valid is high in cycle N+k+1. Minimum latency is 2 cycles.
- Error access: accept at edge N, rsp_valid and rsp_err are high in cycle N+1.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles. rsp_valid and rsp_err follow in the next cycle.
- req_ready is 0 from ACCESS through RESP. The next request can be accepted in the cycle after rsp_valid.
- mem_ack outside ACCESS is ignored.
- mem_ack in the same cycle the counter hits TIMEOUT counts as success; ack has priority.
- Reset asserted mid-ACCESS drops mem_req asynchronously, and no rsp_valid is produced for the aborted transaction.

## Test plan
- SW addr 0x40 data 0xDEADBEEF with immediate ack -> mem_addr=0x10, wstrb=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, err=0, rdata=0.
- SB addr 0x103 data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5. Then LB addr 0x103 with mem_rdata=0xA5000000 -> rdata=0xFFFFFFA5.
- LHU addr 0x22 with mem_rdata=0x8001_1234 -> rdata=0x00008001. LH at the same address -> 0xFFFF8001.
- LW addr 0x102 -> no mem_req; rsp_valid and rsp_err=1 one cycle after accept; rdata=0. Load with funct3=011 gives the same response.
- LW with 3 wait cycles before ack -> mem_req high for 4 cycles with stable outputs; rsp_valid in the following cycle; err=0.
- No ack with TIMEOUT=15 -> mem_req high for 15 cycles, then rsp_err=1. Separately, reset asserted in ACCESS -> mem_req=0 and req_ready=1 immediately, with no rsp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per handshake, word-wide RAM port with
// wait states, byte-lane strobes/replication for stores, lane align + extend for loads.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WADR_W = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic                we_q, we_n;
    logic [2:0]          f3_q, f3_n;
    logic [1:0]          off_q, off_n;
    logic [WADR_W-1:0]   addr_q, addr_n;
    logic [3:0]          wstrb_q, wstrb_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic                err_q, err_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [CNT_W-1:0]    cnt_inc;
    logic                illegal, misaligned;
    logic [3:0]          strobe;
    logic [DATA_W-1:0]   repl;

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                       input logic [1:0] off,
                                                       input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] sh;
        logic [7:0]        b;
        logic [15:0]       h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Request decode: legality, alignment, store strobes and replicated data.
    always_comb begin
        illegal    = req_we ? (req_funct3 >= 3'b011)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                               req_funct3 == 3'b111);
        misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
        case (req_funct3[1:0])
            2'b00: begin
                strobe = 4'b0001 << req_addr[1:0];
                repl   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strobe = 4'b0011 << req_addr[1:0];
                repl   = {2{req_wdata[15:0]}};
            end
            default: begin
                strobe = 4'b1111;
                repl   = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            we_q    <= we_n;
            f3_q    <= f3_n;
            off_q   <= off_n;
            addr_q  <= addr_n;
            wstrb_q <= wstrb_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        we_n    = we_q;
        f3_n    = f3_q;
        off_n   = off_q;
        addr_n  = addr_q;
        wstrb_n = wstrb_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_n    = req_we;
                    f3_n    = req_funct3;
                    off_n   = req_addr[1:0];
                    addr_n  = req_addr[31:2];
                    wstrb_n = req_we ? strobe : 4'b0000;
                    wdata_n = repl;
                    rdata_n = '0;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    if (illegal || misaligned) begin
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rdata_n = we_q ? '0 : load_extend(f3_q, off_q, mem_rdata);
                    state_n = RESP;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        err_n   = 1'b1;
                        rdata_n = '0;
                        state_n = RESP;
                    end
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs decode from state so reset drops them immediately.
    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign mem_we    = mem_req & we_q;
    assign mem_wstrb = mem_req ? wstrb_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
